// File: rtl/instr_serial_tx.sv
// Bit-serial transmitter for the command/confirm servo link.
// Sends one instruction MSB first, then waits for a data_ready acknowledge.
module instr_serial_tx #(
    parameter int WIDTH          = 10,
    parameter int SETUP_CYCLES   = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send,
    input  logic [WIDTH-1:0] instr,
    input  logic             data_ready,
    output logic             command,
    output logic             confirm,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int MAX_PHASE_A = (SETUP_CYCLES > CONFIRM_CYCLES) ? SETUP_CYCLES : CONFIRM_CYCLES;
    localparam int MAX_PHASE   = (MAX_PHASE_A > GAP_CYCLES) ? MAX_PHASE_A : GAP_CYCLES;
    localparam int MAX_CNT     = (ACK_TIMEOUT > MAX_PHASE) ? ACK_TIMEOUT : MAX_PHASE;
    localparam int CNT_W       = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int BIT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP,
        WAIT_ACK
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         sync_reg;
    logic               ack;

    // Two synchroniser flops plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], data_ready};
        end
    end

    assign ack = sync_reg[1] & ~sync_reg[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            cnt_reg     <= '0;
            command     <= 1'b0;
            confirm     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (send) begin
                        shift_reg   <= instr;
                        bit_cnt_reg <= BIT_W'(WIDTH - 1);
                        cnt_reg     <= '0;
                        command     <= instr[WIDTH-1];
                        busy        <= 1'b1;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_reg   <= '0;
                        confirm   <= 1'b1;
                        state_reg <= STROBE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt_reg == CONFIRM_LAST) begin
                        cnt_reg   <= '0;
                        confirm   <= 1'b0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        if (bit_cnt_reg != '0) begin
                            // Next bit is presented from the first SETUP cycle.
                            shift_reg   <= shift_reg << 1;
                            command     <= shift_reg[WIDTH-2];
                            bit_cnt_reg <= bit_cnt_reg - BIT_W'(1);
                            state_reg   <= SETUP;
                        end else begin
                            command   <= 1'b0;
                            state_reg <= WAIT_ACK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_ACK: begin
                    // Acknowledge takes priority over a coincident timeout.
                    if (ack) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    command   <= 1'b0;
                    confirm   <= 1'b0;
                    busy      <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_serial_tx.sv
// Randomised self-checking bench for instr_serial_tx against a per-cycle
// timing model derived from the link's bit period and acknowledge rules.
module tb_instr_serial_tx;

    localparam int W     = 10;
    localparam int S     = 4;
    localparam int C     = 8;
    localparam int G     = 4;
    localparam int T     = 1024;
    localparam int P     = S + C + G;
    localparam int FRAME = W * P;

    logic         clk;
    logic         reset;
    logic         send;
    logic [W-1:0] instr;
    logic         data_ready;
    logic         command;
    logic         confirm;
    logic         busy;
    logic         done;
    logic         timeout_err;

    int n_vec;
    int n_err;

    instr_serial_tx #(
        .WIDTH(W),
        .SETUP_CYCLES(S),
        .CONFIRM_CYCLES(C),
        .GAP_CYCLES(G),
        .ACK_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .send(send),
        .instr(instr),
        .data_ready(data_ready),
        .command(command),
        .confirm(confirm),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout: {busy, command, confirm, done, timeout_err}
    function automatic logic [4:0] obs();
        return {busy, command, confirm, done, timeout_err};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (busy,cmd,conf,done,tmo) at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle i after the accept edge: bit i/P, confirm high in the middle C cycles.
    function automatic logic [4:0] frame_exp(input logic [W-1:0] w, input int i);
        int   bit_idx;
        int   off;
        logic conf;
        bit_idx = i / P;
        off     = i % P;
        conf    = (off >= S) && (off < S + C);
        return {1'b1, w[W-1-bit_idx], conf, 2'b00};
    endfunction

    task automatic do_frame(input logic [W-1:0] w, input bit hold, input int pulse_at,
                            input logic [W-1:0] pulse_word, input int dr_at, input int abort_at);
        send  = 1'b1;
        instr = w;
        tick();
        if (!hold) send = 1'b0;
        instr = W'($urandom);
        $display("frame %h hold=%0d pulse_at=%0d dr_at=%0d abort_at=%0d", w, hold, pulse_at, dr_at, abort_at);
        for (int i = 0; i < FRAME; i++) begin
            check("frame", obs(), frame_exp(w, i));
            if (i == abort_at) begin
                #2;
                reset = 1'b1;
                #1;
                check("async_reset", obs(), 5'b00000);
                tick();
                check("reset_held", obs(), 5'b00000);
                reset = 1'b0;
                send  = 1'b0;
                tick();
                check("after_reset", obs(), 5'b00000);
                return;
            end
            if (i == pulse_at) begin
                send  = 1'b1;
                instr = pulse_word;
            end else if (i == pulse_at + 1 && !hold) begin
                send = 1'b0;
            end
            if (i == dr_at) data_ready = 1'b1;
            tick();
        end
    endtask

    // Offset 0 is the first WAIT_ACK cycle. r >= 0: data_ready rises after
    // offset r, so done is expected at offset r+3; r < 0: no acknowledge.
    task automatic run_wait(input int r_in);
        int         r;
        int         done_off;
        bit         was_high;
        logic [4:0] e;
        r        = r_in;
        was_high = data_ready;
        if (was_high && r >= 0 && r < 2) r = 2;
        done_off = (r >= 0) ? r + 3 : 32'h4000_0000;
        for (int off = 0; off <= T; off++) begin
            if (done_off <= T && off == done_off) e = 5'b00010;
            else if (off == T)                    e = 5'b00001;
            else                                  e = 5'b10000;
            check("wait_ack", obs(), e);
            if (e != 5'b10000) begin
                $display("ack phase r=%0d ended at offset %0d (%s)", r, off, (e == 5'b00010) ? "done" : "timeout");
                break;
            end
            if (r >= 0 && was_high && off == r - 2) data_ready = 1'b0;
            if (r >= 0 && off == r) data_ready = 1'b1;
            tick();
        end
    endtask

    task automatic idle_check();
        tick();
        check("idle", obs(), 5'b00000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        bit           hold;
        int           pulse_at;
        int           dr_at;
        int           r;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        send       = 1'b0;
        instr      = '0;
        data_ready = 1'b0;
        tick();
        tick();
        check("reset_state", obs(), 5'b00000);
        reset = 1'b0;
        idle_check();

        // Known pattern, acknowledge 20 cycles into WAIT_ACK.
        do_frame(10'h3A5, 1'b0, -1, '0, -1, -1);
        run_wait(20);
        idle_check();

        // No acknowledge: timeout after T cycles.
        data_ready = 1'b0;
        do_frame(W'($urandom), 1'b0, -1, '0, -1, -1);
        run_wait(-1);
        idle_check();

        // Level held high from before send must not acknowledge.
        data_ready = 1'b1;
        tick();
        tick();
        do_frame(W'($urandom), 1'b0, -1, '0, -1, -1);
        run_wait(30);
        idle_check();

        // Asynchronous reset in the middle of bit 4's strobe, then a clean frame.
        data_ready = 1'b0;
        do_frame(W'($urandom), 1'b0, -1, '0, -1, 4 * P + S + 3);
        do_frame(W'($urandom), 1'b0, -1, '0, -1, -1);
        run_wait(5);
        idle_check();

        // send pulse with another word mid-frame is ignored.
        do_frame(10'h155, 1'b0, 70, 10'h1FF, -1, -1);
        run_wait(15);
        idle_check();

        // send held high: back-to-back frames with a single idle cycle.
        do_frame(W'($urandom), 1'b1, -1, '0, -1, -1);
        run_wait(10);
        do_frame(W'($urandom), 1'b0, -1, '0, -1, -1);
        run_wait(0);
        idle_check();

        // Acknowledge coinciding with the last timeout cycle wins; one later loses.
        data_ready = 1'b0;
        do_frame(W'($urandom), 1'b0, -1, '0, -1, -1);
        run_wait(T - 3);
        idle_check();
        data_ready = 1'b0;
        do_frame(W'($urandom), 1'b0, -1, '0, -1, -1);
        run_wait(T - 2);
        idle_check();
        idle_check();
        idle_check();

        for (int k = 0; k < 12; k++) begin
            w        = W'($urandom);
            hold     = ($urandom_range(0, 2) == 0);
            pulse_at = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 150) : -1;
            dr_at    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 150) : -1;
            r        = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 60);
            do_frame(w, hold, pulse_at, W'($urandom), dr_at, -1);
            run_wait(r);
            if (!hold) idle_check();
        end
        send = 1'b0;
        idle_check();
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
